// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: ID read ports, EX/WB write-back port, issue port
// and the pending-write count. The register file attaches through the slave modport.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0]      rd_en_i;
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic                wr_en_i;
  logic [AW-1:0]       wr_addr_i;
  logic [XLEN-1:0]     wr_data_i;
  logic                iss_en_i;
  logic [AW-1:0]       iss_addr_i;
  logic [AW:0]         busy_cnt_o;

  modport slave (
    input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i,
    output rd_data_o, rd_busy_o, busy_cnt_o
  );

  modport master (
    output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i,
    input  rd_data_o, rd_busy_o, busy_cnt_o
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file (x0 hardwired to zero) with a per-register pending-write
// scoreboard for RAW hazard detection. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     busy_cnt_q, busy_cnt_d;
  logic            wr_vld, iss_vld, cnt_inc, cnt_dec;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves
  // it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    wr_vld  = bus.wr_en_i  && (bus.wr_addr_i  != '0);
    iss_vld = bus.iss_en_i && (bus.iss_addr_i != '0);
    cnt_inc = iss_vld && !busy_q[bus.iss_addr_i];
    // A same-address issue keeps the bit set, so the write-back does not retire it.
    cnt_dec = wr_vld && busy_q[bus.wr_addr_i]
              && !(iss_vld && (bus.iss_addr_i == bus.wr_addr_i));

    busy_d = busy_q;
    if (wr_vld)  busy_d[bus.wr_addr_i]  = 1'b0;
    if (iss_vld) busy_d[bus.iss_addr_i] = 1'b1;

    busy_cnt_d = busy_cnt_q;
    unique case ({cnt_inc, cnt_dec})
      2'b10:   busy_cnt_d = busy_cnt_q + CNT_ONE;
      2'b01:   busy_cnt_d = busy_cnt_q - CNT_ONE;
      default: busy_cnt_d = busy_cnt_q;
    endcase
  end

  // NOTE: the array itself is cleared on reset because software may read any
  // register before writing it and must see zero; this keeps it in flops, not SRAM.
  // NOTE: state updates use <= so all flops sample pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (wr_vld) regs_q[bus.wr_addr_i] <= bus.wr_data_i;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.busy_cnt_o = busy_cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = bus.rd_addr_i[k*AW +: AW];

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (rst_n && bus.rd_en_i[k] && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_vld && (bus.wr_addr_i == addr)) begin
          data = bus.wr_data_i;
          busy = iss_vld && (bus.iss_addr_i == addr);
        end else
`endif
        begin
          data = regs_q[addr];
          busy = busy_q[addr];
        end
      end
    end

    assign bus.rd_data_o[k*XLEN +: XLEN] = data;
    assign bus.rd_busy_o[k]              = busy;
  end

  a_cnt_is_popcount: assert property (@(posedge clk) disable iff (!rst_n)
    busy_cnt_q == (AW+1)'($countones(busy_q)));
  a_x0_never_busy: assert property (@(posedge clk) disable iff (!rst_n) !busy_q[0]);
endmodule
